// File: rtl/stack_pkg.sv
// Shared types for the stack access controller: request opcodes, FSM states, default widths.
package stack_pkg;

    localparam int STK_ADDR_W = 8;
    localparam int STK_DATA_W = 10;

    typedef enum logic [1:0] {
        OP_NOP  = 2'd0,
        OP_PUSH = 2'd1,
        OP_POP  = 2'd2,
        OP_LOAD = 2'd3
    } stk_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR   = 2'd1,
        RD   = 2'd2,
        RSP  = 2'd3
    } state_t;

endpackage

// File: rtl/stack_sp_reg.sv
// Stack pointer plus occupancy counter; the stack grows downward, so a push decrements SP.
module stack_sp_reg #(
    parameter int ADDR_W = 8
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_val,
    input  logic              incr,
    input  logic              decr,
    output logic [ADDR_W-1:0] sp,
    output logic [ADDR_W:0]   depth
);

    localparam logic [ADDR_W:0] DEPTH_MAX = {1'b1, {ADDR_W{1'b0}}};

    // Depth saturates at both ends so that an unchecked wrap never reports a bogus occupancy.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sp    <= '0;
            depth <= '0;
        end else if (load) begin
            sp    <= load_val;
            depth <= '0;
        end else if (incr) begin
            sp <= sp + 1'b1;
            if (depth != '0)
                depth <= depth - 1'b1;
        end else if (decr) begin
            sp <= sp - 1'b1;
            if (depth != DEPTH_MAX)
                depth <= depth + 1'b1;
        end
    end

endmodule

// File: rtl/stack_access_ctrl.sv
// PUSH/POP/LOAD engine in front of a 1-cycle synchronous scratch RAM.
// Define STACK_BOUNDS_EN to reject overflowing pushes / underflowing pops and raise a sticky ERR.
module stack_access_ctrl
    import stack_pkg::*;
#(
    parameter int ADDR_W = STK_ADDR_W,
    parameter int DATA_W = STK_DATA_W
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              REQ_VALID,
    output logic              REQ_READY,
    input  logic [1:0]        REQ_OP,
    input  logic [DATA_W-1:0] REQ_DATA,
    output logic              RSP_VALID,
    input  logic              RSP_READY,
    output logic [DATA_W-1:0] RSP_DATA,
    output logic [ADDR_W-1:0] MEM_ADDR,
    output logic              MEM_WE,
    output logic [DATA_W-1:0] MEM_WDATA,
    input  logic [DATA_W-1:0] MEM_RDATA,
    output logic [ADDR_W-1:0] SP_OUT,
    output logic              EMPTY,
    output logic              FULL,
    output logic              ERR
);

    localparam logic [ADDR_W:0] DEPTH_MAX = {1'b1, {ADDR_W{1'b0}}};

    state_t            state, nstate;
    stk_op_t           op;
    logic              accept;
    logic [ADDR_W-1:0] sp;
    logic [ADDR_W:0]   depth;
    logic              sp_load, sp_incr, sp_decr;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rsp_data_q;
    logic              pop_err_q;
    logic              push_bad, pop_bad;

    assign op     = stk_op_t'(REQ_OP);
    assign accept = REQ_VALID && (state == IDLE);

`ifdef STACK_BOUNDS_EN
    logic err_q;

    assign push_bad = (depth == DEPTH_MAX);
    assign pop_bad  = (depth == '0);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            err_q <= 1'b0;
        else if (accept && (((op == OP_PUSH) && push_bad) || ((op == OP_POP) && pop_bad)))
            err_q <= 1'b1;
    end

    assign ERR = err_q;
`else
    assign push_bad = 1'b0;
    assign pop_bad  = 1'b0;
    assign ERR      = 1'b0;
`endif

    stack_sp_reg #(.ADDR_W(ADDR_W)) u_sp (
        .CLK      (CLK),
        .RST      (RST),
        .load     (sp_load),
        .load_val (REQ_DATA[ADDR_W-1:0]),
        .incr     (sp_incr),
        .decr     (sp_decr),
        .sp       (sp),
        .depth    (depth)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            state <= IDLE;
        else
            state <= nstate;
    end

    // SP moves on a pop only once the result is consumed, so a stalled response never skews it.
    always_comb begin
        nstate  = state;
        sp_load = 1'b0;
        sp_incr = 1'b0;
        sp_decr = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    case (op)
                        OP_PUSH: if (!push_bad) nstate = WR;
                        OP_POP:  nstate = RD;
                        OP_LOAD: sp_load = 1'b1;
                        default: ;
                    endcase
                end
            end
            WR: begin
                sp_decr = 1'b1;
                nstate  = IDLE;
            end
            RD:  nstate = RSP;
            RSP: begin
                if (RSP_READY) begin
                    nstate  = IDLE;
                    sp_incr = !pop_err_q;
                end
            end
            default: nstate = IDLE;
        endcase
    end

    // MEM_ADDR already shows SP while idle, so RAM data for a pop lands during RD.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wdata_q    <= '0;
            pop_err_q  <= 1'b0;
            rsp_data_q <= '0;
        end else begin
            if (accept && (op == OP_PUSH))
                wdata_q <= REQ_DATA;
            if (accept && (op == OP_POP))
                pop_err_q <= pop_bad;
            if (state == RD)
                rsp_data_q <= pop_err_q ? '0 : MEM_RDATA;
        end
    end

    assign REQ_READY = (state == IDLE);
    assign RSP_VALID = (state == RSP);
    assign RSP_DATA  = rsp_data_q;
    assign MEM_WE    = (state == WR);
    assign MEM_ADDR  = (state == WR) ? (sp - 1'b1) : sp;
    assign MEM_WDATA = (state == WR) ? wdata_q : '0;
    assign SP_OUT    = sp;
    assign EMPTY     = (depth == '0);
    assign FULL      = (depth == DEPTH_MAX);

endmodule

// File: tb/tb_stack_access_ctrl.sv
// Scoreboard bench for stack_access_ctrl: directed cases then randomized traffic vs. a queue/array model.
module tb_stack_access_ctrl;
    import stack_pkg::*;

    localparam int AW    = 8;
    localparam int DW    = 10;
    localparam int DEPTH = 256;
`ifdef STACK_BOUNDS_EN
    localparam bit BOUNDS = 1'b1;
`else
    localparam bit BOUNDS = 1'b0;
`endif

    logic          CLK = 1'b0;
    logic          RST;
    logic          REQ_VALID = 1'b0;
    logic          REQ_READY;
    logic [1:0]    REQ_OP = 2'd0;
    logic [DW-1:0] REQ_DATA = '0;
    logic          RSP_VALID;
    logic          RSP_READY = 1'b0;
    logic [DW-1:0] RSP_DATA;
    logic [AW-1:0] MEM_ADDR;
    logic          MEM_WE;
    logic [DW-1:0] MEM_WDATA;
    logic [DW-1:0] MEM_RDATA = '0;
    logic [AW-1:0] SP_OUT;
    logic          EMPTY, FULL, ERR;

    stack_access_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .CLK(CLK), .RST(RST),
        .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_OP(REQ_OP), .REQ_DATA(REQ_DATA),
        .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_DATA(RSP_DATA),
        .MEM_ADDR(MEM_ADDR), .MEM_WE(MEM_WE), .MEM_WDATA(MEM_WDATA), .MEM_RDATA(MEM_RDATA),
        .SP_OUT(SP_OUT), .EMPTY(EMPTY), .FULL(FULL), .ERR(ERR)
    );

    always #5 CLK = ~CLK;

    // Scratch RAM stub: synchronous read, data the cycle after the address.
    logic [DW-1:0] ram [DEPTH];
    initial for (int i = 0; i < DEPTH; i++) ram[i] = '0;
    always @(posedge CLK) begin
        if (MEM_WE) ram[MEM_ADDR] <= MEM_WDATA;
        MEM_RDATA <= ram[MEM_ADDR];
    end

    typedef struct { int addr; logic [DW-1:0] data; } wr_t;

    int            m_sp = 0, m_depth = 0;
    bit            m_err = 1'b0;
    logic [DW-1:0] m_mem [DEPTH];
    wr_t           wr_q[$];
    logic [DW-1:0] exp_q[$];
    int            checks = 0, errors = 0;
    bit            hold = 1'b0;

    initial for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model(input logic [1:0] op, input logic [DW-1:0] d);
        case (op)
            2'd1: begin
                if (BOUNDS && m_depth == DEPTH) m_err = 1'b1;
                else begin
                    m_sp = (m_sp + DEPTH - 1) % DEPTH;
                    m_mem[m_sp] = d;
                    wr_q.push_back('{m_sp, d});
                    if (m_depth < DEPTH) m_depth++;
                end
            end
            2'd2: begin
                if (BOUNDS && m_depth == 0) begin
                    m_err = 1'b1;
                    exp_q.push_back('0);
                end else begin
                    exp_q.push_back(m_mem[m_sp]);
                    m_sp = (m_sp + 1) % DEPTH;
                    if (m_depth > 0) m_depth--;
                end
            end
            2'd3: begin
                m_sp = int'(d) % DEPTH;
                m_depth = 0;
            end
            default: ;
        endcase
    endtask

    // Random consumer backpressure, changed away from the sampling edge.
    initial forever begin
        @(posedge CLK);
        #1 RSP_READY = hold ? 1'b0 : ($urandom % 3 != 0);
    end

    // Monitor: every write and every consumed response is matched against the scoreboard.
    wr_t           mw;
    logic [DW-1:0] mr;
    always @(negedge CLK) begin
        if (!RST) begin
            if (MEM_WE) begin
                if (wr_q.size() == 0) chk("unexpected_write", {24'd0, MEM_ADDR}, 32'hFFFF_FFFF);
                else begin
                    mw = wr_q.pop_front();
                    chk("wr_addr", MEM_ADDR, mw.addr);
                    chk("wr_data", MEM_WDATA, mw.data);
                end
            end
            if (RSP_VALID && RSP_READY) begin
                if (exp_q.size() == 0) chk("unexpected_rsp", RSP_DATA, 32'hFFFF_FFFF);
                else begin
                    mr = exp_q.pop_front();
                    chk("rsp_data", RSP_DATA, mr);
                end
            end
        end
    end

    task automatic do_req(input logic [1:0] op, input logic [DW-1:0] d);
        int n = 0;
        @(negedge CLK);
        REQ_VALID = 1'b1; REQ_OP = op; REQ_DATA = d;
        while (!REQ_READY && n < 50) begin @(negedge CLK); n++; end
        if (!REQ_READY) begin
            chk("req_timeout", 0, 1);
            REQ_VALID = 1'b0;
            return;
        end
        model(op, d);
        @(posedge CLK);
        #1 REQ_VALID = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge CLK);
        while (!REQ_READY && n < 60) begin @(negedge CLK); n++; end
        chk("idle_timeout", REQ_READY, 1);
        chk("sp", SP_OUT, m_sp);
        chk("empty", EMPTY, m_depth == 0);
        chk("full", FULL, m_depth == DEPTH);
        chk("err", ERR, m_err);
    endtask

    task automatic wait_rsp_valid();
        int n = 0;
        @(negedge CLK);
        while (!RSP_VALID && n < 20) begin @(negedge CLK); n++; end
        chk("rsp_timeout", RSP_VALID, 1);
    endtask

    task automatic model_reset();
        m_sp = 0; m_depth = 0; m_err = 1'b0;
        wr_q.delete(); exp_q.delete();
    endtask

    initial begin
        logic [DW-1:0] d0;
        logic [AW-1:0] sp0;
        int r;

        RST = 1'b1;
        repeat (3) @(negedge CLK);
        chk("rst_rsp_valid", RSP_VALID, 0);
        chk("rst_rsp_data", RSP_DATA, 0);
        chk("rst_mem_we", MEM_WE, 0);
        chk("rst_mem_addr", MEM_ADDR, 0);
        chk("rst_mem_wdata", MEM_WDATA, 0);
        chk("rst_sp", SP_OUT, 0);
        chk("rst_empty", EMPTY, 1);
        chk("rst_full", FULL, 0);
        chk("rst_err", ERR, 0);
        RST = 1'b0;
        chk("rst_req_ready", REQ_READY, 1);

        // push 0x155 from SP=0 lands at 0xFF in the cycle after accept
        do_req(2'd1, 10'h155);
        @(negedge CLK);
        chk("t1_we", MEM_WE, 1);
        chk("t1_addr", MEM_ADDR, 8'hFF);
        chk("t1_wdata", MEM_WDATA, 10'h155);
        wait_idle();

        // LIFO order
        do_req(2'd3, 10'h000); wait_idle();
        do_req(2'd1, 10'h011); wait_idle();
        do_req(2'd1, 10'h022); wait_idle();
        do_req(2'd2, 10'h000); wait_idle();
        do_req(2'd2, 10'h000); wait_idle();

        // stalled response
        do_req(2'd1, 10'h2A5); wait_idle();
        hold = 1'b1;
        do_req(2'd2, 10'h000);
        wait_rsp_valid();
        d0 = RSP_DATA; sp0 = SP_OUT;
        chk("t3_data_first", d0, 10'h2A5);
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            chk("t3_valid", RSP_VALID, 1);
            chk("t3_data", RSP_DATA, d0);
            chk("t3_sp", SP_OUT, sp0);
            chk("t3_req_ready", REQ_READY, 0);
        end
        hold = 1'b0;
        wait_idle();

        // LOAD then push
        do_req(2'd3, 10'h080); wait_idle();
        do_req(2'd1, 10'h3FF); wait_idle();
        chk("t4_sp", SP_OUT, 8'h7F);

        // async reset while a response is pending
        hold = 1'b1;
        do_req(2'd1, 10'h0AA); wait_idle();
        do_req(2'd2, 10'h000);
        wait_rsp_valid();
        #2 RST = 1'b1;
        #1;
        model_reset();
        chk("t6_rsp_valid", RSP_VALID, 0);
        chk("t6_sp", SP_OUT, 0);
        chk("t6_empty", EMPTY, 1);
        @(negedge CLK);
        RST = 1'b0; hold = 1'b0;
        chk("t6_req_ready", REQ_READY, 1);

        // pop on empty
        do_req(2'd2, 10'h000); wait_idle();
        chk("t5_sp", SP_OUT, BOUNDS ? 0 : 1);

        // fill to capacity, overflow by one, then drain one
        do_req(2'd3, 10'h000); wait_idle();
        for (int i = 0; i < DEPTH; i++) begin
            do_req(2'd1, DW'($urandom));
            wait_idle();
        end
        chk("full_after_fill", FULL, 1);
        do_req(2'd1, 10'h1C3); wait_idle();
        do_req(2'd2, 10'h000); wait_idle();
        chk("full_after_pop", FULL, 0);

        // randomized traffic
        for (int i = 0; i < 300; i++) begin
            r = $urandom % 10;
            if (r == 0)      do_req(2'd0, DW'($urandom));
            else if (r <= 4) do_req(2'd1, DW'($urandom));
            else if (r <= 8) do_req(2'd2, DW'($urandom));
            else             do_req(2'd3, DW'($urandom));
            wait_idle();
        end

        repeat (3) @(negedge CLK);
        chk("drain_wr_q", wr_q.size(), 0);
        chk("drain_exp_q", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
